// File: rtl/mem_wb_skid_stage_if.sv
// Handshake and data bundle between the MEM stage, the MEM/WB skid stage and the writeback port.
// The slave modport is the stage's view; the master modport is the view of whatever drives it.
interface mem_wb_skid_stage_if #(
  parameter int DATA_W = 64,
  parameter int RD_W   = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] read_data_in;
  logic [DATA_W-1:0] result_alu_in;
  logic [RD_W-1:0]   rd_in;
  logic              memtoreg_in;
  logic              regwrite_in;
  logic              flush;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] readdata;
  logic [DATA_W-1:0] result_alu_out;
  logic [RD_W-1:0]   rd;
  logic              memtoreg;
  logic              regwrite;
  logic [DATA_W-1:0] wb_data;
  logic [1:0]        occupancy;

  modport master (
    output in_valid, read_data_in, result_alu_in, rd_in, memtoreg_in, regwrite_in, flush,
    output out_ready,
    input  in_ready, out_valid, readdata, result_alu_out, rd, memtoreg, regwrite, wb_data,
    input  occupancy
  );

  modport slave (
    input  in_valid, read_data_in, result_alu_in, rd_in, memtoreg_in, regwrite_in, flush,
    input  out_ready,
    output in_ready, out_valid, readdata, result_alu_out, rd, memtoreg, regwrite, wb_data,
    output occupancy
  );
endinterface

// File: rtl/mem_wb_skid_stage.sv
// MEM/WB pipeline stage with valid/ready handshake, two-entry skid buffer (M = output, S = skid),
// synchronous flush, x0 write suppression and a writeback mux fed only from the output register.
module mem_wb_skid_stage #(
  parameter int DATA_W         = 64,
  parameter int RD_W           = 5,
  parameter bit ZERO_REG_GUARD = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  mem_wb_skid_stage_if.slave  bus
);

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] alu;
    logic [RD_W-1:0]   rd;
    logic              memtoreg;
    logic              regwrite;
  } entry_t;

  entry_t            m_q, m_d;
  entry_t            s_q, s_d;
  entry_t            in_entry;
  logic              m_valid_q, m_valid_d;
  logic              s_valid_q, s_valid_d;
  logic              in_ready_q, in_ready_d;
  logic              accept;
  logic              drain;
  logic              rd_is_zero;
  logic [DATA_W-1:0] wb_data_w;

  always_comb begin
    rd_is_zero        = (bus.rd_in == '0);
    in_entry.rdata    = bus.read_data_in;
    in_entry.alu      = bus.result_alu_in;
    in_entry.rd       = bus.rd_in;
    in_entry.memtoreg = bus.memtoreg_in;
    in_entry.regwrite = bus.regwrite_in & ~(ZERO_REG_GUARD & rd_is_zero);
  end

  assign accept = bus.in_valid & in_ready_q;
  assign drain  = m_valid_q & bus.out_ready;

  always_comb begin
    m_d       = m_q;
    s_d       = s_q;
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    if (bus.flush) begin
      // Data fields keep their stale values; only the valids matter after a kill.
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (!m_valid_q || drain) begin
      if (s_valid_q) begin
        m_d       = s_q;
        m_valid_d = 1'b1;
        s_valid_d = 1'b0;
      end else if (accept) begin
        m_d       = in_entry;
        m_valid_d = 1'b1;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (accept) begin
      s_d       = in_entry;
      s_valid_d = 1'b1;
    end
    // Ready is a flop of the next skid state, so out_ready never reaches in_ready combinationally.
    in_ready_d = ~s_valid_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      m_q        <= '0;
      s_q        <= '0;
      m_valid_q  <= 1'b0;
      s_valid_q  <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      m_q        <= m_d;
      s_q        <= s_d;
      m_valid_q  <= m_valid_d;
      s_valid_q  <= s_valid_d;
      in_ready_q <= in_ready_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_wb_mux
      assign wb_data_w[gi] = m_q.memtoreg ? m_q.rdata[gi] : m_q.alu[gi];
    end
  endgenerate

  assign bus.in_ready       = in_ready_q;
  assign bus.out_valid      = m_valid_q;
  assign bus.readdata       = m_q.rdata;
  assign bus.result_alu_out = m_q.alu;
  assign bus.rd             = m_q.rd;
  assign bus.memtoreg       = m_q.memtoreg;
  assign bus.regwrite       = m_valid_q & m_q.regwrite;
  assign bus.wb_data        = wb_data_w;
  assign bus.occupancy      = {1'b0, m_valid_q} + {1'b0, s_valid_q};

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Self-checking bench for mem_wb_skid_stage: directed scenarios plus a randomized run
// against a queue model of the stage contents (front = output entry).
module tb_mem_wb_skid_stage;

  localparam int DATA_W = 64;
  localparam int RD_W   = 5;

  logic clk;
  logic reset;

  mem_wb_skid_stage_if #(.DATA_W(DATA_W), .RD_W(RD_W)) bus ();
  mem_wb_skid_stage_if #(.DATA_W(DATA_W), .RD_W(RD_W)) bus0 ();

  mem_wb_skid_stage #(.DATA_W(DATA_W), .RD_W(RD_W), .ZERO_REG_GUARD(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  mem_wb_skid_stage #(.DATA_W(DATA_W), .RD_W(RD_W), .ZERO_REG_GUARD(1'b0)) dut_noguard (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] alu;
    logic [RD_W-1:0]   rd;
    logic              m2r;
    logic              rw;
  } ent_t;

  ent_t mq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic drive(input logic v, input logic [RD_W-1:0] r, input logic [DATA_W-1:0] alu,
                       input logic [DATA_W-1:0] rdata, input logic m2r, input logic rw);
    bus.in_valid      = v;
    bus.rd_in         = r;
    bus.result_alu_in = alu;
    bus.read_data_in  = rdata;
    bus.memtoreg_in   = m2r;
    bus.regwrite_in   = rw;
  endtask

  // Apply the stage rules to the model for the inputs currently driven, then cross the edge.
  task automatic step();
    ent_t e;
    bit   room;
    e.rdata = bus.read_data_in;
    e.alu   = bus.result_alu_in;
    e.rd    = bus.rd_in;
    e.m2r   = bus.memtoreg_in;
    e.rw    = bus.regwrite_in && (bus.rd_in != 0);
    if (!reset || bus.flush) begin
      mq.delete();
    end else begin
      room = (mq.size() < 2);
      if (mq.size() > 0 && bus.out_ready) void'(mq.pop_front());
      if (bus.in_valid && room) mq.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b1, 5'd7, 64'hDEAD, 64'hBEEF, 1'b1, 1'b1);
    bus.out_ready = 1'b1;
    step();
    step();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    n_checks++; if (bus.occupancy !== 2'd0) begin n_fail++; $display("FAIL reset_occupancy got %0d want 0", bus.occupancy); end
    n_checks++; if (bus.readdata !== 64'd0) begin n_fail++; $display("FAIL reset_readdata got %h want 0", bus.readdata); end
    n_checks++; if (bus.result_alu_out !== 64'd0) begin n_fail++; $display("FAIL reset_alu got %h want 0", bus.result_alu_out); end
    n_checks++; if (bus.rd !== 5'd0) begin n_fail++; $display("FAIL reset_rd got %0d want 0", bus.rd); end
    n_checks++; if (bus.memtoreg !== 1'b0) begin n_fail++; $display("FAIL reset_memtoreg got %b want 0", bus.memtoreg); end
    n_checks++; if (bus.regwrite !== 1'b0) begin n_fail++; $display("FAIL reset_regwrite got %b want 0", bus.regwrite); end
    n_checks++; if (bus.wb_data !== 64'd0) begin n_fail++; $display("FAIL reset_wb_data got %h want 0", bus.wb_data); end
    $display("reset: held two cycles, occupancy=%0d", bus.occupancy);
    reset = 1'b1;
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    step();
  endtask

  task automatic test_streaming();
    logic [DATA_W-1:0] exp_wb;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 5'(i + 1), 64'h10 + 64'(i), 64'h100 + 64'(i), ((i + 1) % 2) == 1, 1'b1);
      step();
      exp_wb = (((i + 1) % 2) == 1) ? 64'h100 + 64'(i) : 64'h10 + 64'(i);
      n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_out_valid[%0d] got %b want 1", i, bus.out_valid); end
      n_checks++; if (bus.rd !== 5'(i + 1)) begin n_fail++; $display("FAIL stream_rd[%0d] got %0d want %0d", i, bus.rd, i + 1); end
      n_checks++; if (bus.wb_data !== exp_wb) begin n_fail++; $display("FAIL stream_wb_data[%0d] got %h want %h", i, bus.wb_data, exp_wb); end
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready[%0d] got %b want 1", i, bus.in_ready); end
      n_checks++; if (bus.regwrite !== 1'b1) begin n_fail++; $display("FAIL stream_regwrite[%0d] got %b want 1", i, bus.regwrite); end
      $display("stream: rd=%0d wb_data=%h", bus.rd, bus.wb_data);
    end
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    step();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drained got %b want 0", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    drive(1'b1, 5'h0A, 64'hA0, 64'hA1, 1'b0, 1'b1);
    step();
    drive(1'b1, 5'h0B, 64'hB0, 64'hB1, 1'b1, 1'b1);
    step();
    drive(1'b1, 5'h0C, 64'hC0, 64'hC1, 1'b0, 1'b1);
    n_checks++; if (bus.occupancy !== 2'd2) begin n_fail++; $display("FAIL bp_occupancy got %0d want 2", bus.occupancy); end
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got %b want 0", bus.in_ready); end
    step();
    n_checks++; if (bus.rd !== 5'h0A) begin n_fail++; $display("FAIL bp_hold_rd got %h want 0a", bus.rd); end
    n_checks++; if (bus.occupancy !== 2'd2) begin n_fail++; $display("FAIL bp_c_held got %0d want 2", bus.occupancy); end
    bus.out_ready = 1'b1;
    step();
    n_checks++; if (bus.rd !== 5'h0B) begin n_fail++; $display("FAIL bp_second_rd got %h want 0b", bus.rd); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_rise got %b want 1", bus.in_ready); end
    n_checks++; if (bus.wb_data !== 64'hB1) begin n_fail++; $display("FAIL bp_second_wb got %h want b1", bus.wb_data); end
    step();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    n_checks++; if (bus.rd !== 5'h0C) begin n_fail++; $display("FAIL bp_third_rd got %h want 0c", bus.rd); end
    n_checks++; if (bus.occupancy !== 2'd1) begin n_fail++; $display("FAIL bp_third_occ got %0d want 1", bus.occupancy); end
    $display("backpressure: A,B,C emerged, last rd=%h", bus.rd);
    step();
    n_checks++; if (bus.occupancy !== 2'd0) begin n_fail++; $display("FAIL bp_empty got %0d want 0", bus.occupancy); end
  endtask

  task automatic test_x0_guard();
    bus.out_ready  = 1'b1;
    bus0.out_ready = 1'b1;
    drive(1'b1, 5'd0, 64'h55, 64'h66, 1'b0, 1'b1);
    bus0.in_valid = 1'b1; bus0.rd_in = 5'd0; bus0.regwrite_in = 1'b1;
    bus0.result_alu_in = 64'h77; bus0.read_data_in = 64'h88; bus0.memtoreg_in = 1'b0;
    step();
    bus0.in_valid = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL x0_out_valid got %b want 1", bus.out_valid); end
    n_checks++; if (bus.regwrite !== 1'b0) begin n_fail++; $display("FAIL x0_guarded got %b want 0", bus.regwrite); end
    n_checks++; if (bus0.regwrite !== 1'b1) begin n_fail++; $display("FAIL x0_unguarded got %b want 1", bus0.regwrite); end
    n_checks++; if (bus0.wb_data !== 64'h77) begin n_fail++; $display("FAIL x0_unguarded_wb got %h want 77", bus0.wb_data); end
    drive(1'b1, 5'd3, 64'h55, 64'h66, 1'b0, 1'b1);
    step();
    n_checks++; if (bus.regwrite !== 1'b1) begin n_fail++; $display("FAIL x0_nonzero_rd got %b want 1", bus.regwrite); end
    $display("x0 guard: guarded rd0 suppressed, unguarded rd0 regwrite=%b", bus0.regwrite);
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    step();
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    drive(1'b1, 5'd4, 64'h40, 64'h41, 1'b0, 1'b1);
    step();
    drive(1'b1, 5'd5, 64'h50, 64'h51, 1'b0, 1'b1);
    step();
    drive(1'b1, 5'd6, 64'h60, 64'h61, 1'b0, 1'b1);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid got %b want 0", bus.out_valid); end
    n_checks++; if (bus.occupancy !== 2'd0) begin n_fail++; $display("FAIL flush_occupancy got %0d want 0", bus.occupancy); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready got %b want 1", bus.in_ready); end
    n_checks++; if (bus.regwrite !== 1'b0) begin n_fail++; $display("FAIL flush_regwrite got %b want 0", bus.regwrite); end
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    step();
    n_checks++; if (bus.occupancy !== 2'd0) begin n_fail++; $display("FAIL flush_dropped_input got %0d want 0", bus.occupancy); end
    bus.out_ready = 1'b1;
    drive(1'b1, 5'd9, 64'h90, 64'h91, 1'b0, 1'b1);
    step();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    n_checks++; if (bus.occupancy !== 2'd0) begin n_fail++; $display("FAIL flush_drain_occ got %0d want 0", bus.occupancy); end
    $display("flush: occupancy after kill=%0d", bus.occupancy);
  endtask

  task automatic test_reset_mid_stall();
    bus.out_ready = 1'b0;
    drive(1'b1, 5'd12, 64'hC12, 64'hD12, 1'b1, 1'b1);
    step();
    drive(1'b1, 5'd13, 64'hC13, 64'hD13, 1'b1, 1'b1);
    step();
    reset = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    step();
    reset = 1'b1;
    n_checks++; if (bus.occupancy !== 2'd0) begin n_fail++; $display("FAIL rst_stall_occ got %0d want 0", bus.occupancy); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_stall_ready got %b want 1", bus.in_ready); end
    n_checks++; if (bus.wb_data !== 64'd0) begin n_fail++; $display("FAIL rst_stall_wb got %h want 0", bus.wb_data); end
    n_checks++; if (bus.rd !== 5'd0) begin n_fail++; $display("FAIL rst_stall_rd got %0d want 0", bus.rd); end
    $display("reset mid-stall: occupancy=%0d", bus.occupancy);
  endtask

  task automatic test_random();
    ent_t              h;
    logic              exp_ready;
    logic [DATA_W-1:0] exp_wb;
    for (int c = 0; c < 10000; c++) begin
      drive($urandom_range(0, 9) < 7, 5'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
            1'($urandom), 1'($urandom));
      bus.out_ready = ($urandom_range(0, 9) < 6);
      bus.flush     = ($urandom_range(0, 19) == 0);
      #1;
      exp_ready = (mq.size() < 2);
      n_checks++; if (bus.in_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_in_ready[%0d] got %b want %b", c, bus.in_ready, exp_ready); end
      bus.out_ready = ~bus.out_ready;
      #1;
      n_checks++; if (bus.in_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready_comb[%0d] got %b want %b", c, bus.in_ready, exp_ready); end
      bus.out_ready = ~bus.out_ready;
      step();
      n_checks++; if (bus.occupancy !== 2'(mq.size())) begin n_fail++; $display("FAIL rnd_occ[%0d] got %0d want %0d", c, bus.occupancy, mq.size()); end
      n_checks++; if (bus.out_valid !== (mq.size() > 0)) begin n_fail++; $display("FAIL rnd_out_valid[%0d] got %b want %b", c, bus.out_valid, mq.size() > 0); end
      if (mq.size() > 0) begin
        h = mq[0];
        exp_wb = h.m2r ? h.rdata : h.alu;
        n_checks++; if (bus.rd !== h.rd) begin n_fail++; $display("FAIL rnd_rd[%0d] got %h want %h", c, bus.rd, h.rd); end
        n_checks++; if (bus.readdata !== h.rdata) begin n_fail++; $display("FAIL rnd_readdata[%0d] got %h want %h", c, bus.readdata, h.rdata); end
        n_checks++; if (bus.result_alu_out !== h.alu) begin n_fail++; $display("FAIL rnd_alu[%0d] got %h want %h", c, bus.result_alu_out, h.alu); end
        n_checks++; if (bus.memtoreg !== h.m2r) begin n_fail++; $display("FAIL rnd_memtoreg[%0d] got %b want %b", c, bus.memtoreg, h.m2r); end
        n_checks++; if (bus.regwrite !== h.rw) begin n_fail++; $display("FAIL rnd_regwrite[%0d] got %b want %b", c, bus.regwrite, h.rw); end
        n_checks++; if (bus.wb_data !== exp_wb) begin n_fail++; $display("FAIL rnd_wb_data[%0d] got %h want %h", c, bus.wb_data, exp_wb); end
      end else begin
        n_checks++; if (bus.regwrite !== 1'b0) begin n_fail++; $display("FAIL rnd_regwrite_idle[%0d] got %b want 0", c, bus.regwrite); end
      end
    end
    bus.flush = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    $display("random: 10000 cycles, final occupancy=%0d", bus.occupancy);
  endtask

  initial begin
    reset = 1'b0;
    bus.flush = 1'b0; bus.out_ready = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    bus0.in_valid = 1'b0; bus0.rd_in = '0; bus0.regwrite_in = 1'b0; bus0.memtoreg_in = 1'b0;
    bus0.result_alu_in = '0; bus0.read_data_in = '0; bus0.flush = 1'b0; bus0.out_ready = 1'b1;
    test_reset();
    test_streaming();
    test_backpressure();
    test_x0_guard();
    test_flush();
    test_reset_mid_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_wb_skid_stage.md
# mem_wb_skid_stage

Parametrised MEM/WB pipeline stage that replaces the plain MEM/WB register with a valid/ready handshake, a two-entry skid buffer, synchronous flush, x0 write suppression and a precomputed writeback mux. It sits between the data-memory stage and the register-file write port. It sustains one instruction per cycle while allowing writeback backpressure without combinational ready paths to upstream.

## Interface
- DATA_W, 64, width of memory read data, ALU result and writeback data
- RD_W, 5, destination register index width
- ZERO_REG_GUARD, 1, when 1 force regwrite to 0 for rd == 0
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (0 = reset); one clock, sampled on clk rising edge only
- in_valid  input  1  MEM stage presents an instruction
- in_ready  output  1  stage can accept this cycle; registered, equals NOT skid-occupied
- read_data_in  input  DATA_W  memory read data
- result_alu_in  input  DATA_W  ALU result
- rd_in  input  RD_W  destination register
- memtoreg_in  input  1  select memory data for writeback
- regwrite_in  input  1  instruction writes register file
- flush  input  1  synchronous kill of all held entries
- out_valid  output  1  output entry valid
- out_ready  input  1  writeback consumes output entry
- readdata  output  DATA_W  held read data
- result_alu_out  output  DATA_W  held ALU result
- rd  output  RD_W  held destination
- memtoreg  output  1  held select
- regwrite  output  1  out_valid AND held (guarded) regwrite
- wb_data  output  DATA_W  memtoreg ? readdata : result_alu_out (combinational from output register)
- occupancy  output  2  entries held: 0, 1 or 2

## Operation
- Two slots: M (output register, drives all output fields) and S (skid register); each has a valid bit.
- accept = in_valid AND in_ready; drain = out_valid AND out_ready; out_valid = M.valid.
- Captured regwrite = regwrite_in AND (rd_in != 0) when ZERO_REG_GUARD = 1, else regwrite_in.
- Update per rising edge, priority order:
  - reset == 0: M, S cleared (all fields and valids 0).
  - flush == 1: M.valid = S.valid = 0; data fields may keep old values; input this cycle dropped even if in_valid.
  - M empty or drain: if S.valid then M <= S, S.valid <= 0; else if accept then M <= input; else M.valid <= 0.
  - M valid and not drain: if accept then S <= input (only possible when S empty); M holds.
- in_ready = NOT S.valid, driven from register, no combinational path from out_ready.
- With S.valid = 1, accept impossible; S drains into M on the next drain cycle.
- Order preserved: M always older than S.
- occupancy = M.valid + S.valid.
- Output fields unchanged whenever M holds (stable under backpressure).
- regwrite output gated by out_valid: never asserted when out_valid = 0, even if field data is stale.

## Timing
- Reset values: out_valid 0, in_ready 1, readdata 0, result_alu_out 0, rd 0, memtoreg 0, regwrite 0, wb_data 0, occupancy 0.
- Latency: input accepted at edge N appears on outputs after edge N (one cycle) when M empty or draining.
- Throughput: one accept per cycle while out_ready = 1 continuously.
- Backpressure: first stalled cycle absorbs one extra entry into S; in_ready falls after that edge; rises the cycle after S moves to M.
- Flush and accept same cycle: flush wins, occupancy 0 next cycle, in_ready 1.
- Flush and drain same cycle: the drained entry counts as consumed; nothing remains.
- Reset asserted mid-stall: all contents lost, same values as power-on reset next cycle.
- wb_data and regwrite combinational from M only; no input-to-output combinational path.

## Test plan
- Reset: hold reset = 0 two cycles with in_valid = 1 -> out_valid 0, in_ready 1, occupancy 0, all data outputs 0.
- Streaming: out_ready = 1, send rd = 1..8, alu = 0x10..0x17, memtoreg alternating -> each appears one cycle later, wb_data selects readdata on odd entries, no bubbles.
- Backpressure: send A, B, C with out_ready = 0 from cycle 1 -> A in M, B in S, in_ready 0, occupancy 2, C held upstream; release out_ready -> A, B, C emerge in order.
- x0 guard: rd_in = 0, regwrite_in = 1 -> regwrite 0; with ZERO_REG_GUARD = 0 -> regwrite 1.
- Flush: occupancy 2 plus in_valid = 1 and flush = 1 -> next cycle out_valid 0, occupancy 0, in_ready 1, regwrite 0.
- Random: random in_valid/out_ready/flush 10k cycles vs scoreboard queue -> no loss, duplication or reordering; in_ready never depends on same-cycle out_ready.
